// File: rtl/dmi_pkg.sv
// dmi_pkg: shared DMI op/resp codes, register addresses and bit positions.
// Optional feature macro used by dmi_target_regs: DMI_TARGET_PROGBUF_EN.
package dmi_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2,
    OP_RSVD  = 2'd3
  } dmi_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } dmi_state_e;

  localparam logic [1:0] RESP_SUCCESS = 2'd0;
  localparam logic [1:0] RESP_FAILED  = 2'd2;

  localparam logic [6:0] ADDR_DATA0     = 7'h04;
  localparam logic [6:0] ADDR_DATA1     = 7'h05;
  localparam logic [6:0] ADDR_DMCONTROL = 7'h10;
  localparam logic [6:0] ADDR_DMSTATUS  = 7'h11;
  localparam logic [6:0] ADDR_PROGBUF0  = 7'h20;
  localparam logic [6:0] ADDR_PROGBUF7  = 7'h27;

  localparam int unsigned DMCTRL_HALTREQ   = 31;
  localparam int unsigned DMCTRL_RESUMEREQ = 30;
  localparam int unsigned DMCTRL_NDMRESET  = 1;
  localparam int unsigned DMCTRL_DMACTIVE  = 0;

  localparam int unsigned DMSTAT_ALLRUNNING = 11;
  localparam int unsigned DMSTAT_ALLHALTED  = 9;
  localparam logic [3:0]  DMSTAT_VERSION    = 4'd2;

endpackage

// File: rtl/dmi_target_regs.sv
// dmi_target_regs: debug register bank, address decode, read mux and
// hart-control outputs. DMI_TARGET_PROGBUF_EN adds progbuf0..7 at 0x20..0x27.
module dmi_target_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        commit,
  input  logic [6:0]  addr,
  input  logic [1:0]  op,
  input  logic [31:0] wdata,
  input  logic        hart_halted,
  output logic [1:0]  rresp,
  output logic [31:0] rdata,
  output logic        haltreq,
  output logic        resumereq,
  output logic        ndmreset,
  output logic        dmactive
);
  import dmi_pkg::*;

  logic [31:0] data0_q, data1_q;
  logic        haltreq_q, ndmreset_q, dmactive_q, resumereq_q;
  logic        mapped, wr_en;
  logic [31:0] rd_val, dmcontrol_rd, dmstatus_rd;
`ifdef DMI_TARGET_PROGBUF_EN
  logic [31:0] progbuf_q [8];
`endif

  // Fixed-layout views of dmcontrol and dmstatus for the read mux
  always_comb begin
    dmcontrol_rd = '0;
    dmcontrol_rd[DMCTRL_HALTREQ]  = haltreq_q;
    dmcontrol_rd[DMCTRL_NDMRESET] = ndmreset_q;
    dmcontrol_rd[DMCTRL_DMACTIVE] = dmactive_q;
    dmstatus_rd = '0;
    dmstatus_rd[DMSTAT_ALLRUNNING] = !hart_halted;
    dmstatus_rd[DMSTAT_ALLHALTED]  = hart_halted;
    dmstatus_rd[3:0] = DMSTAT_VERSION;
  end

  // Address decode, read mux and response code for the current request
  always_comb begin
    mapped = 1'b1;
    rd_val = '0;
    case (addr)
      ADDR_DATA0:     rd_val = data0_q;
      ADDR_DATA1:     rd_val = data1_q;
      ADDR_DMCONTROL: rd_val = dmcontrol_rd;
      ADDR_DMSTATUS:  rd_val = dmstatus_rd;
      default:        mapped = 1'b0;
    endcase
`ifdef DMI_TARGET_PROGBUF_EN
    if (addr >= ADDR_PROGBUF0 && addr <= ADDR_PROGBUF7) begin
      mapped = 1'b1;
      rd_val = progbuf_q[addr[2:0]];
    end
`endif
    rresp = RESP_SUCCESS;
    rdata = '0;
    wr_en = 1'b0;
    case (op)
      OP_NOP:   ;
      OP_READ:  if (mapped) rdata = rd_val; else rresp = RESP_FAILED;
      OP_WRITE: if (mapped) wr_en = commit; else rresp = RESP_FAILED;
      default:  rresp = RESP_FAILED;
    endcase
  end

  // Register bank; dmactive=0 write holds the DM state cleared
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data0_q     <= '0;
      data1_q     <= '0;
      haltreq_q   <= 1'b0;
      ndmreset_q  <= 1'b0;
      dmactive_q  <= 1'b0;
      resumereq_q <= 1'b0;
`ifdef DMI_TARGET_PROGBUF_EN
      for (int unsigned i = 0; i < 8; i++) progbuf_q[i] <= '0;
`endif
    end else begin
      resumereq_q <= 1'b0;
      if (wr_en) begin
        case (addr)
          ADDR_DATA0: data0_q <= wdata;
          ADDR_DATA1: data1_q <= wdata;
          ADDR_DMCONTROL: begin
            dmactive_q <= wdata[DMCTRL_DMACTIVE];
            if (wdata[DMCTRL_DMACTIVE]) begin
              haltreq_q   <= wdata[DMCTRL_HALTREQ];
              ndmreset_q  <= wdata[DMCTRL_NDMRESET];
              resumereq_q <= wdata[DMCTRL_RESUMEREQ];
            end else begin
              haltreq_q  <= 1'b0;
              ndmreset_q <= 1'b0;
              data0_q    <= '0;
              data1_q    <= '0;
`ifdef DMI_TARGET_PROGBUF_EN
              for (int unsigned i = 0; i < 8; i++) progbuf_q[i] <= '0;
`endif
            end
          end
          default: ;
        endcase
`ifdef DMI_TARGET_PROGBUF_EN
        if (addr >= ADDR_PROGBUF0 && addr <= ADDR_PROGBUF7)
          progbuf_q[addr[2:0]] <= wdata;
`endif
      end
    end
  end

  assign haltreq   = haltreq_q & dmactive_q;
  assign ndmreset  = ndmreset_q & dmactive_q;
  assign resumereq = resumereq_q;
  assign dmactive  = dmactive_q;

endmodule

// File: rtl/dmi_target.sv
// dmi_target: DMI responder top. Request/response handshake FSM, access
// latency counter and request/response latches around dmi_target_regs.
// Optional progbuf registers are enabled by DMI_TARGET_PROGBUF_EN.
module dmi_target #(
  parameter int unsigned ACCESS_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        debug_req_valid,
  output logic        debug_req_ready,
  input  logic [6:0]  debug_req_bits_addr,
  input  logic [1:0]  debug_req_bits_op,
  input  logic [31:0] debug_req_bits_data,
  output logic        debug_resp_valid,
  input  logic        debug_resp_ready,
  output logic [1:0]  debug_resp_bits_resp,
  output logic [31:0] debug_resp_bits_data,
  input  logic        hart_halted,
  output logic        haltreq,
  output logic        resumereq,
  output logic        ndmreset,
  output logic        dmactive
);
  import dmi_pkg::*;

  dmi_state_e  state_q, state_d;
  logic [3:0]  cnt_q;
  logic [6:0]  addr_q;
  logic [1:0]  op_q;
  logic [31:0] wdata_q;
  logic [1:0]  resp_q;
  logic [31:0] rdata_q;
  logic        rdy_q;
  logic        accept, commit;
  logic [1:0]  rresp;
  logic [31:0] rdata;

  // Next-state logic: accept in IDLE, count down in ACCESS, hold in RESP
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: if (debug_req_valid && rdy_q) begin
        accept  = 1'b1;
        state_d = ST_ACCESS;
      end
      ST_ACCESS: if (cnt_q == '0) begin
        commit  = 1'b1;
        state_d = ST_RESP;
      end
      ST_RESP: if (debug_resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State register; ready is registered from next state so it is low in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d == ST_IDLE);
    end
  end

  // Request latch, latency counter and response capture at commit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      addr_q  <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= debug_req_bits_addr;
        op_q    <= debug_req_bits_op;
        wdata_q <= debug_req_bits_data;
        cnt_q   <= 4'(ACCESS_LAT - 1);
      end else if (state_q == ST_ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        resp_q  <= rresp;
        rdata_q <= rdata;
      end
    end
  end

  dmi_target_regs u_regs (
    .clk         (clk),
    .rst         (reset),
    .commit      (commit),
    .addr        (addr_q),
    .op          (op_q),
    .wdata       (wdata_q),
    .hart_halted (hart_halted),
    .rresp       (rresp),
    .rdata       (rdata),
    .haltreq     (haltreq),
    .resumereq   (resumereq),
    .ndmreset    (ndmreset),
    .dmactive    (dmactive)
  );

  assign debug_req_ready      = rdy_q;
  assign debug_resp_valid     = (state_q == ST_RESP);
  assign debug_resp_bits_resp = resp_q;
  assign debug_resp_bits_data = rdata_q;

endmodule

// File: tb/tb_dmi_target.sv
// tb_dmi_target: directed DMI transactions; expected responses are queued at
// issue time and checked by an independent response monitor.
module tb_dmi_target;
  localparam int unsigned LAT = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [6:0]  req_addr;
  logic [1:0]  req_op;
  logic [31:0] req_data;
  logic        resp_valid, resp_ready;
  logic [1:0]  resp_resp;
  logic [31:0] resp_data;
  logic        hart_halted, haltreq, resumereq, ndmreset, dmactive;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   resume_cnt = 0;
  logic prev_valid = 1'b0;

  dmi_target #(.ACCESS_LAT(LAT)) dut (
    .clk                  (clk),
    .reset                (reset),
    .debug_req_valid      (req_valid),
    .debug_req_ready      (req_ready),
    .debug_req_bits_addr  (req_addr),
    .debug_req_bits_op    (req_op),
    .debug_req_bits_data  (req_data),
    .debug_resp_valid     (resp_valid),
    .debug_resp_ready     (resp_ready),
    .debug_resp_bits_resp (resp_resp),
    .debug_resp_bits_data (resp_data),
    .hart_halted          (hart_halted),
    .haltreq              (haltreq),
    .resumereq            (resumereq),
    .ndmreset             (ndmreset),
    .dmactive             (dmactive)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) if (resumereq) resume_cnt++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Response monitor: latency at resp_valid rise, payload at handshake
  always @(negedge clk) begin
    if (resp_valid && !prev_valid) begin
      if (sb.size() == 0) check("unexpected_resp", 32'd1, 32'd0);
      else check("latency", 32'(cyc - sb[0].acc_cyc), 32'(LAT));
    end
    prev_valid = resp_valid;
    if (resp_valid && resp_ready && sb.size() != 0) begin
      exp_t e;
      e = sb.pop_front();
      check("resp_code", 32'(resp_resp), 32'(e.resp));
      check("resp_data", resp_data, e.data);
    end
  end

  task automatic dmi_req(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                         input logic [1:0] er, input logic [31:0] ed);
    bit done = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = a; req_op = op; req_data = d;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (req_ready) begin
        sb.push_back('{er, ed, cyc + 1});
        done = 1;
      end
    end
    @(posedge clk); #1;
    req_valid = 1'b0; req_data = ~d; req_addr = 7'h7F; req_op = 2'd3;
    if (!done) check("req_accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && req_ready) done = 1;
    end
    if (!done) check("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_addr = '0; req_op = '0; req_data = '0;
    resp_ready = 1'b1; hart_halted = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {26'd0, req_ready, resp_valid, haltreq, resumereq, ndmreset, dmactive}, 32'd0);
    reset = 1'b0;
    #1 check("ready_after_release", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("ready_next_cycle", 32'(req_ready), 32'd1);

    // data0 write/read
    dmi_req(7'h04, 2'd2, 32'hDEADBEEF, 2'd0, 32'd0);
    dmi_req(7'h04, 2'd1, 32'h0, 2'd0, 32'hDEADBEEF);

    // haltreq + dmactive, dmstatus view
    dmi_req(7'h10, 2'd2, 32'h80000001, 2'd0, 32'd0);
    wait_done();
    check("haltreq_set", {30'd0, haltreq, dmactive}, 32'd3);
    check("ndmreset_clear", 32'(ndmreset), 32'd0);
    hart_halted = 1'b1;
    dmi_req(7'h11, 2'd1, 32'h0, 2'd0, 32'h00000202);
    wait_done();
    hart_halted = 1'b0;
    dmi_req(7'h11, 2'd1, 32'h0, 2'd0, 32'h00000802);

    // dmactive=0 clears state
    dmi_req(7'h10, 2'd2, 32'h0, 2'd0, 32'd0);
    wait_done();
    check("haltreq_cleared", {30'd0, haltreq, dmactive}, 32'd0);
    dmi_req(7'h04, 2'd1, 32'h0, 2'd0, 32'h0);

    // resume pulse
    wait_done();
    resume_cnt = 0;
    dmi_req(7'h10, 2'd2, 32'h40000001, 2'd0, 32'd0);
    wait_done();
    repeat (3) @(negedge clk);
    check("resume_pulse_cycles", 32'(resume_cnt), 32'd1);
    dmi_req(7'h10, 2'd1, 32'h0, 2'd0, 32'h00000001);

    // ndmreset
    dmi_req(7'h10, 2'd2, 32'h00000003, 2'd0, 32'd0);
    wait_done();
    check("ndmreset_set", {30'd0, ndmreset, dmactive}, 32'd3);
    dmi_req(7'h10, 2'd1, 32'h0, 2'd0, 32'h00000003);

    // failures, nop, read-only dmstatus
    dmi_req(7'h7F, 2'd1, 32'h0, 2'd2, 32'h0);
    dmi_req(7'h04, 2'd3, 32'h0, 2'd2, 32'h0);
    dmi_req(7'h04, 2'd0, 32'h0, 2'd0, 32'h0);
    dmi_req(7'h11, 2'd2, 32'hFFFFFFFF, 2'd0, 32'h0);
    dmi_req(7'h11, 2'd1, 32'h0, 2'd0, 32'h00000802);
`ifdef DMI_TARGET_PROGBUF_EN
    dmi_req(7'h23, 2'd2, 32'hA5A5A5A5, 2'd0, 32'h0);
    dmi_req(7'h23, 2'd1, 32'h0, 2'd0, 32'hA5A5A5A5);
`else
    dmi_req(7'h23, 2'd2, 32'hA5A5A5A5, 2'd2, 32'h0);
    dmi_req(7'h23, 2'd1, 32'h0, 2'd2, 32'h0);
`endif

    // response held under backpressure; new requests ignored
    dmi_req(7'h04, 2'd2, 32'h12345678, 2'd0, 32'd0);
    wait_done();
    resp_ready = 1'b0;
    dmi_req(7'h04, 2'd1, 32'h0, 2'd0, 32'h12345678);
    begin
      bit seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin
        @(negedge clk);
        if (resp_valid) seen = 1;
      end
      check("hold_resp_seen", 32'(seen), 32'd1);
    end
    req_valid = 1'b1; req_addr = 7'h04; req_op = 2'd2; req_data = 32'h0BADF00D;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(resp_valid), 32'd1);
      check("hold_data", resp_data, 32'h12345678);
      check("hold_ready_low", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    wait_done();
    dmi_req(7'h04, 2'd1, 32'h0, 2'd0, 32'h12345678);
    wait_done();

    // reset mid-ACCESS: write to data1 dropped
    @(posedge clk); #1;
    req_valid = 1'b1; req_addr = 7'h05; req_op = 2'd2; req_data = 32'h1;
    begin
      bit ok = 0;
      for (int i = 0; i < 20 && !ok; i++) begin
        @(negedge clk);
        if (req_ready) ok = 1;
      end
      check("midreset_accept", 32'(ok), 32'd1);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1 check("midreset_outputs", {26'd0, req_ready, resp_valid, haltreq, resumereq, ndmreset, dmactive}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    dmi_req(7'h05, 2'd1, 32'h0, 2'd0, 32'h0);
    dmi_req(7'h10, 2'd1, 32'h0, 2'd0, 32'h0);
    wait_done();
    check("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dmi_target.md
# dmi_target

DMI responder: the target end of the 7-bit-address debug module interface driven by the simulation DTM. Accepts one request at a time, performs a read/write on a small debug register bank after a fixed access latency, and returns a response that is held until accepted. Register bank drives hart-control outputs (haltreq, resumereq, ndmreset, dmactive) and reflects hart status inputs.

## Interface
- ACCESS_LAT, 1, cycles from request acceptance to response valid; legal 1..15
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- debug_req_valid  in  1  request valid
- debug_req_ready  out  1  target can accept a request
- debug_req_bits_addr  in  7  register address
- debug_req_bits_op  in  2  0 nop, 1 read, 2 write, 3 reserved
- debug_req_bits_data  in  32  write data
- debug_resp_valid  out  1  response valid
- debug_resp_ready  in  1  initiator accepts response
- debug_resp_bits_resp  out  2  0 success, 2 failed
- debug_resp_bits_data  out  32  read data, 0 for non-reads and failures
- hart_halted  in  1  hart status
- haltreq  out  1  halt request level
- resumereq  out  1  one-cycle resume pulse
- ndmreset  out  1  non-debug-module reset level
- dmactive  out  1  debug module active

## Operation
- FSM states IDLE, ACCESS, RESP. Reset state IDLE, all registers 0.
- IDLE: req_ready=1 (registered, 0 during reset, 1 from first cycle after reset deasserts). valid&&ready latches addr/op/data, loads counter with ACCESS_LAT-1, goes ACCESS.
- ACCESS: req_ready=0. Counter decrements; at 0 performs the access (commit), loads resp, goes RESP.
- RESP: resp_valid=1, resp/data stable until resp_valid&&resp_ready, then IDLE.
- Register map: 0x04 data0 RW32; 0x05 data1 RW32; 0x10 dmcontrol: bit31 haltreq RW, bit30 resumereq W1 (reads 0), bit1 ndmreset RW, bit0 dmactive RW, other bits read 0; 0x11 dmstatus RO: bit11 allrunning=!hart_halted, bit9 allhalted=hart_halted, bits3:0=2, writes ignored with success.
- Outputs: haltreq = dmcontrol.haltreq & dmactive; ndmreset = dmcontrol.ndmreset & dmactive; resumereq pulses one cycle at commit of a write with bit30=1 and dmactive (new value) =1.
- Writing dmactive=0 clears haltreq, ndmreset, data0, data1 (and progbuf if built).
- op 0: success, data 0, no side effects. op 3 or unmapped address: failed, data 0, no side effects.
- Read data sampled at the commit edge (hart_halted value at that edge).

## Timing
- Accept at edge E0; commit and resp_valid rise at edge E0+ACCESS_LAT.
- Write effects (outputs, later reads) visible from same cycle resp_valid rises.
- Resp handshake at edge E1 -> req_ready=1 the following cycle; min request period ACCESS_LAT+2 cycles.
- resp_valid held indefinitely under resp_ready=0; no new request accepted meanwhile.
- req_valid ignored outside IDLE; req fields sampled only at accept edge.
- reset asserted mid-transaction: transaction dropped, no commit, all outputs 0 immediately.

## Configuration
- DMI_TARGET_PROGBUF_EN defined: progbuf0..progbuf7 RW32 at 0x20..0x27, cleared by reset and dmactive=0.
- Undefined: 0x20..0x27 unmapped (failed, data 0).

## Structure
- Package dmi_pkg: op codes, resp codes, register address constants, dmcontrol/dmstatus bit positions.
- Sub-module dmi_target_regs: register bank, decode, read mux, control outputs; top holds FSM, counter, request/response latches.

## Test plan
- Reset release -> req_ready 0 during reset, 1 next cycle; all outputs 0.
- ACCESS_LAT=3: write 0x04=0xDEADBEEF then read 0x04 -> resp_valid 3 cycles after each accept, read resp 0 data 0xDEADBEEF.
- Write 0x10=0x80000001 -> haltreq=1, dmactive=1; hart_halted=1 then read 0x11 -> data 0x00000202; write 0x10=0 -> haltreq=0, data0 cleared.
- Write 0x10=0x40000001 -> resumereq high exactly one cycle, read 0x10 returns 0x00000001.
- Read 0x7F and op 3 -> resp 2 data 0; resp_ready held low 10 cycles -> resp stable, req_ready 0 throughout.
- Reset asserted during ACCESS of write 0x05=1 -> no commit; post-reset read 0x05 returns 0.
